// File: rtl/usb_tx_packet_framer.sv
// USB transmit packet framer: turns START/STREAM/STOP byte writes from the packet
// sender into SYNC, PID, payload, CRC16 and EOP requests for the bit serializer.
module usb_tx_packet_framer (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCTxPortWEn,
    input  logic [7:0] SCTxPortCntl,
    input  logic [7:0] SCTxPortData,
    output logic       SCTxPortRdy,
    output logic [7:0] txByte,
    output logic       txByteValid,
    input  logic       txByteAck,
    output logic       txEOP,
    input  logic       txEOPDone,
    output logic       txBusy
);

    localparam logic [7:0] TX_PACKET_START  = 8'h00;
    localparam logic [7:0] TX_PACKET_STREAM = 8'h01;
    localparam logic [7:0] TX_PACKET_STOP   = 8'h02;
    localparam logic [7:0] SYNC_BYTE        = 8'h80;

    typedef enum logic [3:0] {
        IDLE, SEND_SYNC, SEND_PID, WAIT_DATA, SEND_DATA,
        SEND_CRC_LO, SEND_CRC_HI, SEND_EOP, WAIT_EOP
    } state_t;

    state_t      state, next_state;
    logic [7:0]  pid_reg;
    logic [7:0]  hold_reg;
    logic [15:0] crc;
    logic        wr_ok;

    // Register kept in non-reflected form; data bits enter LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign wr_ok = SCTxPortWEn && SCTxPortRdy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pid_reg  <= 8'h00;
            hold_reg <= 8'h00;
            crc      <= 16'hFFFF;
        end else begin
            if (state == IDLE && wr_ok && SCTxPortCntl == TX_PACKET_START) begin
                pid_reg <= SCTxPortData;
                crc     <= 16'hFFFF;
            end
            if (state == WAIT_DATA && wr_ok && SCTxPortCntl == TX_PACKET_STREAM)
                hold_reg <= SCTxPortData;
            if (state == SEND_DATA && txByteAck)
                crc <= crc16_byte(crc, hold_reg);
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:        if (wr_ok && SCTxPortCntl == TX_PACKET_START) next_state = SEND_SYNC;
            SEND_SYNC:   if (txByteAck) next_state = SEND_PID;
            SEND_PID:    if (txByteAck) next_state = (pid_reg[1:0] == 2'b11) ? WAIT_DATA : SEND_EOP;
            WAIT_DATA: begin
                if (wr_ok && SCTxPortCntl == TX_PACKET_STREAM)    next_state = SEND_DATA;
                else if (wr_ok && SCTxPortCntl == TX_PACKET_STOP) next_state = SEND_CRC_LO;
            end
            SEND_DATA:   if (txByteAck) next_state = WAIT_DATA;
            SEND_CRC_LO: if (txByteAck) next_state = SEND_CRC_HI;
            SEND_CRC_HI: if (txByteAck) next_state = SEND_EOP;
            SEND_EOP:    next_state = WAIT_EOP;
            WAIT_EOP:    if (txEOPDone) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Outputs decode straight from state, so a presented byte cannot move until the
    // ack edge and an ack in the first valid cycle is honoured.
    always_comb begin
        SCTxPortRdy = 1'b0;
        txByte      = 8'h00;
        txByteValid = 1'b0;
        txEOP       = 1'b0;
        txBusy      = (state != IDLE);
        unique case (state)
            IDLE, WAIT_DATA: SCTxPortRdy = 1'b1;
            SEND_SYNC:   begin txByte = SYNC_BYTE;              txByteValid = 1'b1; end
            SEND_PID:    begin txByte = pid_reg;                txByteValid = 1'b1; end
            SEND_DATA:   begin txByte = hold_reg;               txByteValid = 1'b1; end
            SEND_CRC_LO: begin txByte = reflect8(~crc[15:8]);   txByteValid = 1'b1; end
            SEND_CRC_HI: begin txByte = reflect8(~crc[7:0]);    txByteValid = 1'b1; end
            SEND_EOP:    txEOP = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_packet_framer.sv
// Directed bench for usb_tx_packet_framer: a behavioural serializer logs every
// acknowledged byte and EOP; packets come from a vector table plus corner sequences.
module tb_usb_tx_packet_framer;

    localparam logic [7:0] START  = 8'h00;
    localparam logic [7:0] STREAM = 8'h01;
    localparam logic [7:0] STOP   = 8'h02;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       SCTxPortWEn = 1'b0;
    logic [7:0] SCTxPortCntl = 8'h00;
    logic [7:0] SCTxPortData = 8'h00;
    logic       SCTxPortRdy;
    logic [7:0] txByte;
    logic       txByteValid;
    logic       txByteAck = 1'b0;
    logic       txEOP;
    logic       txEOPDone = 1'b0;
    logic       txBusy;

    usb_tx_packet_framer dut (
        .clk(clk), .rst(rst),
        .SCTxPortWEn(SCTxPortWEn), .SCTxPortCntl(SCTxPortCntl), .SCTxPortData(SCTxPortData),
        .SCTxPortRdy(SCTxPortRdy), .txByte(txByte), .txByteValid(txByteValid),
        .txByteAck(txByteAck), .txEOP(txEOP), .txEOPDone(txEOPDone), .txBusy(txBusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pid;
        bit         has_data;
        int         n;
        logic [7:0] d [3];
        int         delay;
        int         exp_n;
        logic [7:0] exp [8];
    } pkt_t;

    int total = 0;
    int bad   = 0;

    logic [7:0] got [$];
    int eop_count = 0;
    int hold_err  = 0;
    int busy_err  = 0;
    int ack_delay = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference CRC16 in reflected form (poly 0xA001), result already in wire order.
    function automatic logic [15:0] crc_ref(input logic [7:0] d [3], input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, d[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic mk(output pkt_t p, input logic [7:0] pid, input bit has_data, input int n,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                      input int delay);
        logic [15:0] c;
        p.pid = pid; p.has_data = has_data; p.n = n;
        p.d[0] = d0; p.d[1] = d1; p.d[2] = d2; p.delay = delay;
        for (int i = 0; i < 8; i++) p.exp[i] = 8'h00;
        p.exp[0] = 8'h80;
        p.exp[1] = pid;
        p.exp_n  = 2;
        if (has_data) begin
            for (int i = 0; i < n; i++) p.exp[2+i] = p.d[i];
            c = crc_ref(p.d, n);
            p.exp[2+n] = c[7:0];
            p.exp[3+n] = c[15:8];
            p.exp_n    = 4 + n;
        end
    endtask

    // Serializer model: acks after ack_delay cycles, answers txEOP with txEOPDone.
    initial begin
        bit         held = 0;
        logic [7:0] held_byte = 8'h00;
        int         wait_cnt = 0;
        int         eop_wait = -1;
        bit         busy_chk = 0;
        forever begin
            @(negedge clk);
            txByteAck = 1'b0;
            txEOPDone = 1'b0;
            if (!rst) begin
                held = 0; eop_wait = -1; busy_chk = 0;
            end else begin
                if (busy_chk) begin
                    if (txBusy) busy_err++;
                    busy_chk = 0;
                end
                if (eop_wait == 0) begin
                    txEOPDone = 1'b1;
                    if (!txBusy) busy_err++;
                    busy_chk = 1;
                    eop_wait = -1;
                end else if (eop_wait > 0) eop_wait--;
                if (txEOP) begin
                    eop_count++;
                    eop_wait = 2;
                end
                if (txByteValid) begin
                    if (!held) begin
                        held = 1; held_byte = txByte; wait_cnt = 0;
                    end else if (txByte !== held_byte) hold_err++;
                    if (SCTxPortRdy) hold_err++;
                    if (wait_cnt >= ack_delay) begin
                        txByteAck = 1'b1;
                        got.push_back(txByte);
                        held = 0;
                    end else wait_cnt++;
                end else if (held) begin
                    hold_err++;
                    held = 0;
                end
            end
        end
    end

    task automatic write(input logic [7:0] cntl, input logic [7:0] data);
        SCTxPortWEn = 1'b1; SCTxPortCntl = cntl; SCTxPortData = data;
        @(negedge clk);
        SCTxPortWEn = 1'b0; SCTxPortCntl = 8'h00; SCTxPortData = 8'h00;
    endtask

    task automatic wait_rdy(input string name);
        int n = 0;
        while (!SCTxPortRdy && n < 300) begin @(negedge clk); n++; end
        if (!SCTxPortRdy) check({name, "_rdy_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (txBusy && n < 500) begin @(negedge clk); n++; end
        if (txBusy) check({name, "_idle_timeout"}, 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_bytes(input string name, input pkt_t p);
        check({name, "_nbytes"}, got.size(), p.exp_n);
        for (int i = 0; i < p.exp_n; i++)
            check($sformatf("%s_byte%0d", name, i), (i < got.size()) ? int'(got[i]) : -1, int'(p.exp[i]));
        check({name, "_eop"}, eop_count, 1);
        check({name, "_hold"}, hold_err, 0);
        check({name, "_busy_edge"}, busy_err, 0);
    endtask

    task automatic clear_log(input int delay);
        got.delete(); eop_count = 0; hold_err = 0; busy_err = 0; ack_delay = delay;
    endtask

    task automatic run_packet(input string name, input pkt_t p);
        clear_log(p.delay);
        write(START, p.pid);
        if (p.has_data) begin
            for (int i = 0; i < p.n; i++) begin
                wait_rdy(name);
                write(STREAM, p.d[i]);
            end
            wait_rdy(name);
            write(STOP, 8'h00);
        end
        wait_idle(name);
        check_bytes(name, p);
    endtask

    pkt_t vec [5];
    pkt_t p;

    initial begin
        mk(vec[0], 8'hD2, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        mk(vec[1], 8'hC3, 1, 0, 8'h00, 8'h00, 8'h00, 1);
        mk(vec[2], 8'h4B, 1, 2, 8'h00, 8'h01, 8'h00, 8);
        mk(vec[3], 8'hC3, 1, 3, 8'hA5, 8'h5A, 8'hFF, 0);
        mk(vec[4], 8'h69, 0, 0, 8'h00, 8'h00, 8'h00, 3);

        repeat (2) @(negedge clk);
        check("rst_rdy",   SCTxPortRdy, 1);
        check("rst_byte",  txByte, 8'h00);
        check("rst_valid", txByteValid, 0);
        check("rst_eop",   txEOP, 0);
        check("rst_busy",  txBusy, 0);
        rst = 1'b1;
        @(negedge clk);

        // Empty payload CRC must come out as two zero bytes.
        check("crc_empty", vec[1].exp[2] | vec[1].exp[3], 8'h00);

        for (int i = 0; i < 5; i++) run_packet($sformatf("vec%0d", i), vec[i]);

        // Stray STREAM/STOP while idle.
        clear_log(0);
        write(STREAM, 8'h33);
        write(STOP, 8'h00);
        repeat (10) @(negedge clk);
        check("idle_ign_bytes", got.size(), 0);
        check("idle_ign_eop", eop_count, 0);
        check("idle_ign_busy", txBusy, 0);

        // START while waiting for data is dropped.
        mk(p, 8'hC3, 1, 1, 8'h11, 8'h00, 8'h00, 2);
        clear_log(2);
        write(START, 8'hC3);
        wait_rdy("restart");
        write(START, 8'hD2);
        wait_rdy("restart");
        write(STREAM, 8'h11);
        wait_rdy("restart");
        write(STOP, 8'h00);
        wait_idle("restart");
        check_bytes("restart", p);

        // Reset in the middle of a data byte hold.
        clear_log(20);
        write(START, 8'hC3);
        wait_rdy("abort");
        write(STREAM, 8'h55);
        repeat (4) @(negedge clk);
        check("abort_pre_valid", txByteValid, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_valid", txByteValid, 0);
        check("abort_byte", txByte, 8'h00);
        check("abort_busy", txBusy, 0);
        check("abort_rdy", SCTxPortRdy, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_eop", eop_count, 0);
        check("abort_idle_busy", txBusy, 0);
        run_packet("post_rst", vec[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/usb_tx_packet_framer.md
USB_TX_PACKET_FRAMER -- requirements
Module: usb_tx_packet_framer

Interface
REQ-001 One clock and one reset: clk, rising-edge; rst, asynchronous, active-low.
REQ-002 clk  input  1  system clock, all state changes on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset, forces all state and outputs to reset values.
REQ-004 SCTxPortWEn  input  1  one-cycle write strobe from packet sender.
REQ-005 SCTxPortCntl  input  8  byte type; encodings are the TX_PACKET_START / TX_PACKET_STREAM / TX_PACKET_STOP codes of the SIE header.
REQ-006 SCTxPortData  input  8  byte payload (PID|~PID on START, data on STREAM, don't-care on STOP).
REQ-007 SCTxPortRdy  output  1  high = a write on SCTxPortWEn this cycle is accepted.
REQ-008 txByte  output  8  byte presented to bit serializer.
REQ-009 txByteValid  output  1  txByte valid; held until txByteAck.
REQ-010 txByteAck  input  1  one-cycle pulse from serializer, byte consumed.
REQ-011 txEOP  output  1  one-cycle pulse requesting serializer to send EOP after last byte.
REQ-012 txEOPDone  input  1  one-cycle pulse, EOP finished on the bus.
REQ-013 txBusy  output  1  high from accepted START until txEOPDone.

Function
REQ-014 States: IDLE, SEND_SYNC, SEND_PID, WAIT_DATA, SEND_DATA, SEND_CRC_LO, SEND_CRC_HI, SEND_EOP, WAIT_EOP.
REQ-015 SCTxPortRdy SHALL be high only in IDLE and WAIT_DATA; writes with SCTxPortRdy low SHALL be ignored.
REQ-016 IDLE: write with START -> latch Data as PID byte, CRC16 <= 16'hFFFF, go SEND_SYNC; STREAM/STOP writes in IDLE ignored.
REQ-017 SEND_SYNC: txByte=8'h80, txByteValid=1; on txByteAck -> SEND_PID.
REQ-018 SEND_PID: txByte=latched PID byte; on txByteAck -> WAIT_DATA if PID[1:0]==2'b11 (DATA0/DATA1), else SEND_EOP.
REQ-019 WAIT_DATA: STREAM write -> latch byte, go SEND_DATA; STOP write -> go SEND_CRC_LO (payload discarded); START write -> ignored.
REQ-020 SEND_DATA: txByte=latched byte; on txByteAck update CRC16 with that byte, return WAIT_DATA.
REQ-021 CRC16: USB polynomial 16'h8005, bits processed LSB first, init 16'hFFFF; transmitted value = bitwise inverse of register, low byte then high byte, each byte bit-reflected as required for LSB-first serialization.
REQ-022 SEND_CRC_LO / SEND_CRC_HI: present respective CRC byte; advance on txByteAck; SEND_CRC_HI -> SEND_EOP.
REQ-023 SEND_EOP: txEOP pulses exactly one cycle, txByteValid=0, -> WAIT_EOP.
REQ-024 WAIT_EOP: on txEOPDone -> IDLE; txBusy drops same edge.
REQ-025 txByteValid SHALL not deassert, and txByte SHALL not change, between assertion and txByteAck.
REQ-026 txByteAck while txByteValid low SHALL be ignored; txByteAck same cycle as txByteValid first asserted SHALL be honoured.
REQ-027 Max byte count not limited by the block; CRC register width exactly 16 bits, no overflow state.
REQ-028 Throughput: at most one byte accepted on the SCTxPort per byte acknowledged by serializer; no internal FIFO beyond one holding register.

Reset
REQ-029 On rst low: state IDLE, SCTxPortRdy=1 after release, txByte=8'h00, txByteValid=0, txEOP=0, txBusy=0, CRC=16'hFFFF, holding register=8'h00.
REQ-030 Reset asserted mid-packet SHALL abort immediately with no txEOP issued; first post-reset packet SHALL frame normally.

Verification
REQ-031 START Data=8'hD2 (ACK), serializer acks every byte -> bytes 80, D2, then one txEOP pulse; no CRC bytes.
REQ-032 START 8'hC3, STOP -> bytes 80, C3, 00, 00, txEOP; txBusy falls on txEOPDone.
REQ-033 START 8'h4B, STREAM 8'h00, STREAM 8'h01, STOP -> 80, 4B, 00, 01, then two CRC bytes matching a CRC16 reference model; txByteAck delayed 8 cycles each -> txByte stable and SCTxPortRdy low throughout each hold.
REQ-034 STREAM and STOP writes while IDLE, START write while WAIT_DATA -> ignored, no bytes or txEOP generated.
REQ-035 rst low during SEND_DATA -> outputs at reset values asynchronously; next START 8'hD2 produces 80, D2, txEOP.
